// File: rtl/mc_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller drives the datapath controls; the datapath returns opcode fields and the ALU zero flag.
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared-memory datapath,
// plus ALU decode for R-type instructions (lw, sw, R, beq, bne, addi, j).
module mc_controller #(
    parameter bit BNE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] alu_decode(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100000: a = 3'b010;
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic       pcen_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [2:0] alucontrol_s;
    logic       illegal_s;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_s       = S_FETCH;
        pcen_s       = 1'b0;
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = ALU_ADD;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = 1'b1;
                pcen_s    = 1'b1;
                next_s    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alusrcb_s = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(bus.funct)) begin
                            next_s = S_EXECUTE;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    OP_BEQ:  next_s = S_BRANCH;
                    OP_BNE: begin
                        if (BNE_EN) begin
                            next_s = S_BRANCH;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    OP_ADDI: next_s = S_ADDIEX;
                    OP_J:    next_s = S_JUMP;
                    default: illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (bus.op == OP_LW) begin
                    next_s = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    next_s = S_MEMWR;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                next_s = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s    = 1'b1;
                alucontrol_s = alu_decode(bus.funct);
                next_s       = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                pcsrc_s      = 2'b01;
                if (bus.op == OP_BEQ) begin
                    pcen_s = bus.zero;
                end else if (BNE_EN && (bus.op == OP_BNE)) begin
                    pcen_s = ~bus.zero;
                end else begin
                    pcen_s = 1'b0;
                end
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                next_s    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc_s = 2'b10;
                pcen_s  = 1'b1;
            end
            default: next_s = S_FETCH;
        endcase
    end

    // Enables are held off for the whole reset pulse, not just until the state register clears.
    assign bus.pcen       = pcen_s & ~reset;
    assign bus.irwrite    = irwrite_s & ~reset;
    assign bus.memwrite   = memwrite_s & ~reset;
    assign bus.regwrite   = regwrite_s & ~reset;
    assign bus.illegal_op = illegal_s & ~reset;
    assign bus.iord       = iord_s;
    assign bus.regdst     = regdst_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.alucontrol = alucontrol_s;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class state by state and
// compares the full control word against hand-derived values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_nb;
    logic [5:0] op_v;
    logic [5:0] funct_v;
    logic       zero_v;
    int         n_cmp = 0;
    int         n_err = 0;

    mc_if bus();
    mc_if bus_nb();

    assign bus.op       = op_v;
    assign bus.funct    = funct_v;
    assign bus.zero     = zero_v;
    assign bus_nb.op    = op_v;
    assign bus_nb.funct = funct_v;
    assign bus_nb.zero  = zero_v;

    mc_controller #(.BNE_EN(1'b1)) dut    (.clk(clk), .reset(reset),  .bus(bus));
    mc_controller #(.BNE_EN(1'b0)) dut_nb (.clk(clk), .reset(rst_nb), .bus(bus_nb));

    always #5 clk = ~clk;

    // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state}
    wire [19:0] ctl = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                       bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                       bus.illegal_op, bus.state};
    wire [19:0] ctl_nb = {bus_nb.pcen, bus_nb.iord, bus_nb.memwrite, bus_nb.irwrite, bus_nb.regdst,
                          bus_nb.memtoreg, bus_nb.regwrite, bus_nb.alusrca, bus_nb.alusrcb,
                          bus_nb.pcsrc, bus_nb.alucontrol, bus_nb.illegal_op, bus_nb.state};

    localparam logic [19:0] E_RESET   = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0, 4'd0};
    localparam logic [19:0] E_FETCH   = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 1'b0, 4'd0};
    localparam logic [19:0] E_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0, 4'd1};
    localparam logic [19:0] E_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1, 4'd1};
    localparam logic [19:0] E_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 4'd2};
    localparam logic [19:0] E_MEMRD   = {8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0, 4'd3};
    localparam logic [19:0] E_MEMWB   = {8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b0, 4'd4};
    localparam logic [19:0] E_MEMWR   = {8'b0110_0000, 2'b00, 2'b00, 3'b010, 1'b0, 4'd5};
    localparam logic [19:0] E_ALUWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0, 4'd7};
    localparam logic [19:0] E_BR_T    = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0, 4'd8};
    localparam logic [19:0] E_BR_NT   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0, 4'd8};
    localparam logic [19:0] E_ADDIEX  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 4'd9};
    localparam logic [19:0] E_ADDIWB  = {8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0, 4'd10};
    localparam logic [19:0] E_JUMP    = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0, 4'd11};

    function automatic logic [19:0] e_exec(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, alu, 1'b0, 4'd6};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rst_nb  = 1'b1;
        op_v    = 6'b100011;
        funct_v = 6'b000000;
        zero_v  = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== E_RESET) begin n_err++; $display("FAIL reset_hold: got %h want %h", ctl, E_RESET); end
        tick();
        n_cmp++;
        if (ctl !== E_RESET) begin n_err++; $display("FAIL reset_edge: got %h want %h", ctl, E_RESET); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== E_FETCH) begin n_err++; $display("FAIL reset_release: got %h want %h", ctl, E_FETCH); end
        tick();
        tick();
        tick();
        n_cmp++;
        if (ctl !== E_MEMRD) begin n_err++; $display("FAIL pre_abort_memrd: got %h want %h", ctl, E_MEMRD); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== E_RESET) begin n_err++; $display("FAIL async_reset: got %h want %h", ctl, E_RESET); end
        tick();
        n_cmp++;
        if (ctl !== E_RESET) begin n_err++; $display("FAIL abort_no_memwb: got %h want %h", ctl, E_RESET); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== E_FETCH) begin n_err++; $display("FAIL abort_release: got %h want %h", ctl, E_FETCH); end
    endtask

    task automatic test_lw();
        logic [19:0] seq[$];
        op_v = 6'b100011;
        seq  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (ctl !== seq[i]) begin n_err++; $display("FAIL lw step%0d: got %h want %h", i, ctl, seq[i]); end
            tick();
        end
    endtask

    task automatic test_sw();
        logic [19:0] seq[$];
        op_v = 6'b101011;
        seq  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (ctl !== seq[i]) begin n_err++; $display("FAIL sw step%0d: got %h want %h", i, ctl, seq[i]); end
            tick();
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  functs[5] = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};
        logic [2:0]  alus[5]   = '{3'b110, 3'b111, 3'b010, 3'b000, 3'b001};
        logic [19:0] seq[$];
        op_v = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct_v = functs[k];
            seq     = '{E_FETCH, E_DECODE, e_exec(alus[k]), E_ALUWB};
            for (int i = 0; i < seq.size(); i++) begin
                n_cmp++;
                if (ctl !== seq[i]) begin
                    n_err++;
                    $display("FAIL rtype f=%b step%0d: got %h want %h", funct_v, i, ctl, seq[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops[4]   = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic        zeros[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [19:0] brs[4]   = '{E_BR_T, E_BR_NT, E_BR_NT, E_BR_T};
        logic [19:0] seq[$];
        for (int k = 0; k < 4; k++) begin
            op_v   = ops[k];
            zero_v = zeros[k];
            seq    = '{E_FETCH, E_DECODE, brs[k]};
            for (int i = 0; i < seq.size(); i++) begin
                n_cmp++;
                if (ctl !== seq[i]) begin
                    n_err++;
                    $display("FAIL branch op=%b z=%b step%0d: got %h want %h", op_v, zero_v, i, ctl, seq[i]);
                end
                tick();
            end
        end
        zero_v = 1'b0;
    endtask

    task automatic test_addi();
        logic [19:0] seq[$];
        op_v = 6'b001000;
        seq  = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB};
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (ctl !== seq[i]) begin n_err++; $display("FAIL addi step%0d: got %h want %h", i, ctl, seq[i]); end
            tick();
        end
    endtask

    task automatic test_jump();
        logic [19:0] seq[$];
        op_v = 6'b000010;
        seq  = '{E_FETCH, E_DECODE, E_JUMP};
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (ctl !== seq[i]) begin n_err++; $display("FAIL jump step%0d: got %h want %h", i, ctl, seq[i]); end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops[3]    = '{6'b111111, 6'b000000, 6'b000001};
        logic [5:0]  functs[3] = '{6'b100000, 6'b000000, 6'b100000};
        logic [19:0] seq[$];
        seq = '{E_FETCH, E_DEC_ILL, E_FETCH};
        for (int k = 0; k < 3; k++) begin
            op_v    = ops[k];
            funct_v = functs[k];
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (ctl !== seq[i]) begin
                    n_err++;
                    $display("FAIL illegal op=%b f=%b step%0d: got %h want %h", op_v, funct_v, i, ctl, seq[i]);
                end
                tick();
            end
        end
        n_cmp++;
        if (ctl !== seq[2]) begin n_err++; $display("FAIL illegal_return: got %h want %h", ctl, seq[2]); end
    endtask

    task automatic test_bne_disabled();
        logic [19:0] seq[$];
        op_v   = 6'b000101;
        zero_v = 1'b0;
        rst_nb = 1'b0;
        #1;
        seq = '{E_FETCH, E_DEC_ILL, E_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (ctl_nb !== seq[i]) begin
                n_err++;
                $display("FAIL bne_disabled step%0d: got %h want %h", i, ctl_nb, seq[i]);
            end
            if (i < seq.size() - 1) tick();
        end
        rst_nb = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops[3] = '{6'b101011, 6'b000010, 6'b100011};
        logic [19:0] seq[$];
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR,
                E_FETCH, E_DECODE, E_JUMP,
                E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 0) op_v = ops[0];
            if (i == 4) op_v = ops[1];
            if (i == 7) op_v = ops[2];
            n_cmp++;
            if (ctl !== seq[i]) begin n_err++; $display("FAIL b2b step%0d: got %h want %h", i, ctl, seq[i]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch();
        test_addi();
        test_jump();
        test_illegal();
        test_bne_disabled();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the MIPS core. It sequences a shared-memory datapath (one memory for instructions and data, one ALU, with IR/A/B/ALUOut registers) through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK steps.
- Moore FSM plus combinational ALU decode. It sits beside the datapath inside the multicycle MIPS top and replaces the single-cycle decoder.
- Subset: lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, j.

Parameters:
- BNE_EN, 1, enables bne (op 000101). When 0, bne is decoded as illegal.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26], taken from the instruction register; stable from DECODE to end of instruction
- funct  input  6  instr[5:0], from the instruction register
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register enable
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  write-back select: 0=ALUOut, 1=mem data
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0=PC, 1=A register
- alusrcb  output  2  ALU B select: 00=B, 01=4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  3  add=010, sub=110, and=000, or=001, slt=111
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported op/funct
- state  output  4  current state encoding (debug)

Behaviour:
- State register is async-reset to FETCH (0). While reset=1, all enables (pcen, irwrite, memwrite, regwrite) and illegal_op are forced to 0; other outputs take FETCH values.
- Outputs decode from state only, except pcen (uses zero) and illegal_op / alucontrol in EXECUTE (use op/funct). Unlisted outputs are 0; unlisted alucontrol is 010.
- States and per-state outputs:
  - 0 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, irwrite=1, pcen=1. Next: DECODE.
  - 1 DECODE: alusrca=0, alusrcb=11 (precompute branch target). Next by op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 000101 -> BRANCH (if BNE_EN)
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - otherwise -> FETCH with illegal_op=1
  - 2 MEMADR: alusrca=1, alusrcb=10. Next: op=lw -> MEMRD, op=sw -> MEMWR.
  - 3 MEMRD: iord=1. Next: MEMWB.
  - 4 MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - 5 MEMWR: iord=1, memwrite=1. Next: FETCH.
  - 6 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Next: ALUWB.
  - 7 ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - 8 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen=zero for beq, pcen=~zero for bne. Next: FETCH.
  - 9 ADDIEX: alusrca=1, alusrcb=10. Next: ADDIWB.
  - 10 ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - 11 JUMP: pcsrc=10, pcen=1. Next: FETCH.
  - 12-15 unused: all enables 0, next FETCH.
- Illegal funct on R-type: detected in DECODE. illegal_op pulses and the FSM returns to FETCH; no register write occurs.
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 2.
- Reset asserted mid-instruction aborts it; the pending regwrite/memwrite is never issued.
- Each instruction has exactly one pcen pulse in FETCH, plus at most one in BRANCH/JUMP.

Test Plan:
- Reset pulse mid-MEMRD -> state=0 asynchronously; enables stay 0 while reset=1; the first cycle after release is FETCH with irwrite=1, pcen=1.
- op=100011 -> states 0,1,2,3,4; only state 4 has regwrite=1 with memtoreg=1, regdst=0; iord=1 in state 3.
- op=101011 -> states 0,1,2,5; memwrite=1 only in state 5; regwrite is never asserted.
- op=000000, funct=100010 then 101010 -> alucontrol=110 then 111 in EXECUTE; ALUWB has regdst=1, regwrite=1.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BRANCH. With zero=0 -> pcen=0. op=000101 gives the inverse. BNE_EN=0 with op=000101 -> illegal_op=1, no BRANCH state.
- op=000010 -> JUMP with pcsrc=10, pcen=1. op=111111 or funct=000000 (R-type) -> illegal_op=1 in DECODE, next state FETCH, no writes.
